adc9826_cfg_seq: RTL and testbench

Table-driven configuration sequencer for the AD9826 serial-config engine (adc9826_cfg), in the sclk domain. It replaces the hard-coded two-write FSM in the top level. On a power-up auto-trigger or a PS start pulse, it reads register entries from the plparam RAM and issues one cfg write per entry. It then pulses cfg start, waits for the engine's done indication, and reports status back to the PS GPIO and the LED logic.

---
 rtl/adc9826_cfg_seq.sv | 148 ++++++++++++++
 tb/tb_adc9826_cfg_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc9826_cfg_seq.sv
// Table-driven AD9826 configuration sequencer: walks register entries in plparam RAM,
// issues one cfg write per entry, then starts the serial engine and waits for done.
module adc9826_cfg_seq #(
    parameter int         POWERUP_CYCLES = 65534,
    parameter int         MAX_ENTRIES    = 8,
    parameter logic [7:0] BASE_ADDR      = 8'h40,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        autostart_en_in,
    input  logic        start_in,
    output logic        ram_rd_o,
    output logic [7:0]  ram_addr_o,
    input  logic [31:0] ram_din,
    output logic        cfg_wr_o,
    output logic [2:0]  cfg_addr_o,
    output logic [8:0]  cfg_data_o,
    output logic        cfg_start_o,
    input  logic        cfg_done_in,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_o,
    output logic [3:0]  entry_cnt_o
);
    localparam int PU_W = $clog2(POWERUP_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, DECODE, WRITE, START, WAIT_DONE, DONE
    } state_t;

    state_t          r_state, w_next;
    logic [PU_W-1:0] r_pu_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_start_d, r_done_d;
    logic [3:0]      r_idx, r_entry_cnt;
    logic            r_end;
    logic [2:0]      r_eaddr, r_cfg_addr;
    logic [8:0]      r_edata, r_cfg_data;
    logic [1:0]      r_err;
    logic            w_trig, w_done_edge, w_timeout, w_last, w_unused;

    assign w_trig      = (start_in && !r_start_d) ||
                         (autostart_en_in && r_pu_cnt == PU_W'(POWERUP_CYCLES - 1));
    assign w_done_edge = cfg_done_in && !r_done_d;
    assign w_timeout   = r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
    assign w_last      = r_idx == 4'(MAX_ENTRIES - 1);
    assign w_unused    = ^{ram_din[30:19], ram_din[15:9]};

    assign cfg_addr_o  = r_cfg_addr;
    assign cfg_data_o  = r_cfg_data;
    assign err_o       = r_err;
    assign entry_cnt_o = r_entry_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        ram_rd_o    = 1'b0;
        ram_addr_o  = '0;
        cfg_wr_o    = 1'b0;
        cfg_start_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (r_state)
            IDLE: begin
                busy_o = 1'b0;
                if (w_trig) w_next = RD_REQ;
            end
            RD_REQ: begin
                ram_rd_o   = 1'b1;
                ram_addr_o = BASE_ADDR + {2'b00, r_idx, 2'b00};
                w_next     = RD_WAIT;
            end
            RD_WAIT: w_next = DECODE;
            // An end marker in slot 0 means an empty table: skip the engine entirely.
            DECODE: begin
                if (r_end) w_next = (r_idx == '0) ? DONE : START;
                else       w_next = WRITE;
            end
            WRITE: begin
                cfg_wr_o = 1'b1;
                w_next   = w_last ? START : RD_REQ;
            end
            START: begin
                cfg_start_o = 1'b1;
                w_next      = WAIT_DONE;
            end
            WAIT_DONE: if (w_done_edge || w_timeout) w_next = DONE;
            DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pu_cnt    <= '0;
            r_to_cnt    <= '0;
            r_start_d   <= 1'b0;
            r_done_d    <= 1'b0;
            r_idx       <= '0;
            r_entry_cnt <= '0;
            r_end       <= 1'b0;
            r_eaddr     <= '0;
            r_edata     <= '0;
            r_cfg_addr  <= '0;
            r_cfg_data  <= '0;
            r_err       <= '0;
        end else begin
            r_start_d <= start_in;
            r_done_d  <= cfg_done_in;
            if (r_pu_cnt != PU_W'(POWERUP_CYCLES)) r_pu_cnt <= r_pu_cnt + 1'b1;
            // Zero during START, so expiry lands TIMEOUT_CYCLES after the start pulse.
            r_to_cnt <= (r_state == START || r_state == WAIT_DONE) ? r_to_cnt + 1'b1 : '0;
            case (r_state)
                IDLE: if (w_trig) begin
                    r_idx       <= '0;
                    r_entry_cnt <= '0;
                    r_err       <= '0;
                end
                RD_WAIT: begin
                    r_end   <= ram_din[31];
                    r_eaddr <= ram_din[18:16];
                    r_edata <= ram_din[8:0];
                end
                DECODE: if (!r_end) begin
                    r_cfg_addr <= r_eaddr;
                    r_cfg_data <= r_edata;
                end
                WRITE: begin
                    r_idx       <= r_idx + 1'b1;
                    r_entry_cnt <= r_entry_cnt + 1'b1;
                    if (w_last) r_err[1] <= 1'b1;
                end
                WAIT_DONE: if (w_timeout && !w_done_edge) r_err[0] <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adc9826_cfg_seq.sv
// Bench for adc9826_cfg_seq: RAM and cfg-engine models, table-driven and random runs
// checked against a table-walk model, plus power-up, mid-run start and reset sequences.
module tb_adc9826_cfg_seq;
    localparam int         PU   = 16;
    localparam int         TO   = 32;
    localparam int         MAXE = 8;
    localparam logic [7:0] BASE = 8'h40;

    logic        clk = 1'b0, rst_n = 1'b0, autostart_en_in = 1'b0, start_in = 1'b0;
    logic        cfg_done_in = 1'b0;
    logic [31:0] ram_din = '0;
    logic        ram_rd_o, cfg_wr_o, cfg_start_o, busy_o, done_o;
    logic [7:0]  ram_addr_o;
    logic [2:0]  cfg_addr_o;
    logic [8:0]  cfg_data_o;
    logic [1:0]  err_o;
    logic [3:0]  entry_cnt_o;

    adc9826_cfg_seq #(.POWERUP_CYCLES(PU), .MAX_ENTRIES(MAXE), .BASE_ADDR(BASE),
                      .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .autostart_en_in(autostart_en_in), .start_in(start_in),
        .ram_rd_o(ram_rd_o), .ram_addr_o(ram_addr_o), .ram_din(ram_din),
        .cfg_wr_o(cfg_wr_o), .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
        .cfg_start_o(cfg_start_o), .cfg_done_in(cfg_done_in), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .entry_cnt_o(entry_cnt_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, cyc = 0;
    logic [31:0] mem [256];
    logic [31:0] cur_tbl [8];

    initial forever begin @(posedge clk); cyc++; end

    // synchronous-read RAM: data appears the cycle after the strobe
    always @(posedge clk) if (ram_rd_o) ram_din <= mem[ram_addr_o];

    // monitor
    logic [11:0] wq [$];
    int          wc [$];
    logic [7:0]  rq [$];
    int          rc [$];
    int          n_start, s_cyc, n_done, d_cyc;
    logic [3:0]  d_cnt;
    logic [1:0]  d_err;
    logic        d_busy;

    initial forever begin
        @(negedge clk);
        if (cfg_wr_o) begin wq.push_back({cfg_addr_o, cfg_data_o}); wc.push_back(cyc); end
        if (ram_rd_o) begin rq.push_back(ram_addr_o); rc.push_back(cyc); end
        if (cfg_start_o) begin n_start++; s_cyc = cyc; end
        if (done_o) begin
            n_done++; d_cyc = cyc; d_cnt = entry_cnt_o; d_err = err_o; d_busy = busy_o;
        end
    end

    // cfg engine: raise done resp_dly cycles after start (0 = never), or hold it high
    int resp_dly = 0;
    bit hold_high = 1'b0;
    initial forever begin
        @(negedge clk);
        if (hold_high) cfg_done_in = 1'b1;
        else if (cfg_start_o && resp_dly > 0) begin
            repeat (resp_dly) @(negedge clk);
            cfg_done_in = 1'b1;
            repeat (2) @(negedge clk);
            cfg_done_in = 1'b0;
        end else cfg_done_in = 1'b0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        wq.delete(); wc.delete(); rq.delete(); rc.delete();
        n_start = 0; n_done = 0; s_cyc = -1; d_cyc = -1;
    endtask

    // One run of cur_tbl; expectations come from walking the table by its rules.
    task automatic run_case(input string nm, input int dly, input bit hold, input bit auto_trig);
        int n, term, p, s, dexp, nrd;
        bit has_start, tmo;
        logic [1:0] eerr;
        for (int i = 0; i < 8; i++) mem[int'(BASE) + 4*i] = cur_tbl[i];
        resp_dly = dly; hold_high = hold;
        if (auto_trig) begin
            rst_n = 1'b0; autostart_en_in = 1'b1;
            repeat (2) @(negedge clk);
            #1; clear_mon(); rst_n = 1'b1; p = cyc + PU;
            repeat (PU) @(negedge clk);
        end else begin
            @(negedge clk); #1; clear_mon(); start_in = 1'b1; p = cyc + 1;
            @(negedge clk);
            start_in = 1'b0;
        end
        chk({nm, ".busy_at_trig"}, busy_o, 1);
        chk({nm, ".err_cleared"}, err_o, 0);
        chk({nm, ".cnt_cleared"}, entry_cnt_o, 0);
        for (int k = 0; k < 400 && n_done == 0; k++) begin @(negedge clk); #1; end
        repeat (3) @(negedge clk);
        #1;

        n = 0; term = -1;
        for (int i = 0; i < 8; i++)
            if (term < 0) begin
                if (cur_tbl[i][31]) term = i;
                else n++;
            end
        nrd       = (term < 0) ? MAXE : term + 1;
        has_start = (term != 0);
        s         = p + 4*n + ((term > 0) ? 3 : 0);
        tmo       = hold || dly < 1 || dly > TO - 1;
        dexp      = !has_start ? p + 3 : (tmo ? s + TO : s + dly + 1);
        eerr      = {term < 0, has_start && tmo};

        chk({nm, ".n_wr"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            chk($sformatf("%s.wr%0d", nm, i), wq[i], {cur_tbl[i][18:16], cur_tbl[i][8:0]});
            chk($sformatf("%s.wr%0d_cyc", nm, i), wc[i], p + 3 + 4*i);
        end
        chk({nm, ".n_rd"}, rq.size(), nrd);
        for (int i = 0; i < nrd && i < rq.size(); i++) begin
            chk($sformatf("%s.rd%0d", nm, i), rq[i], int'(BASE) + 4*i);
            chk($sformatf("%s.rd%0d_cyc", nm, i), rc[i], p + 4*i);
        end
        chk({nm, ".n_start"}, n_start, has_start);
        if (has_start) chk({nm, ".start_cyc"}, s_cyc, s);
        chk({nm, ".n_done"}, n_done, 1);
        chk({nm, ".done_cyc"}, d_cyc, dexp);
        chk({nm, ".cnt"}, d_cnt, n);
        chk({nm, ".err"}, d_err, eerr);
        chk({nm, ".busy_at_done"}, d_busy, 0);
        hold_high = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] tbl [8];
        int          dly;
        bit          hold;
        int          exp_cnt;
        logic [1:0]  exp_err;
    } vec_t;
    vec_t vecs [8];

    initial begin
        vecs[0].tbl = '{32'h000000C8, 32'h000100C0, 32'h80000000, 0, 0, 0, 0, 0};
        vecs[0].dly = 20; vecs[0].hold = 0; vecs[0].exp_cnt = 2; vecs[0].exp_err = 2'b00;
        vecs[1].tbl = '{32'h80000000, 32'h000100C0, 0, 0, 0, 0, 0, 0};
        vecs[1].dly = 20; vecs[1].hold = 0; vecs[1].exp_cnt = 0; vecs[1].exp_err = 2'b00;
        vecs[2].tbl = '{32'h00000001, 32'h00010002, 32'h00020003, 32'h00030004,
                        32'h00040005, 32'h00050006, 32'h00060007, 32'h000701FF};
        vecs[2].dly = 10; vecs[2].hold = 0; vecs[2].exp_cnt = 8; vecs[2].exp_err = 2'b10;
        vecs[3].tbl = vecs[0].tbl;
        vecs[3].dly = 0;  vecs[3].hold = 0; vecs[3].exp_cnt = 2; vecs[3].exp_err = 2'b01;
        vecs[4].tbl = vecs[0].tbl;
        vecs[4].dly = 31; vecs[4].hold = 0; vecs[4].exp_cnt = 2; vecs[4].exp_err = 2'b00;
        vecs[5].tbl = vecs[0].tbl;
        vecs[5].dly = 5;  vecs[5].hold = 1; vecs[5].exp_cnt = 2; vecs[5].exp_err = 2'b01;
        vecs[6].tbl = '{32'h7FF8FE12, 32'h0001FE34, 32'h40020156, 32'h0FF30078,
                        32'h00040100, 32'h12350009, 32'h000601FF, 32'hFFFFFFFF};
        vecs[6].dly = 5;  vecs[6].hold = 0; vecs[6].exp_cnt = 7; vecs[6].exp_err = 2'b00;
        vecs[7].tbl = vecs[2].tbl;
        vecs[7].dly = 0;  vecs[7].hold = 0; vecs[7].exp_cnt = 8; vecs[7].exp_err = 2'b11;

        for (int i = 0; i < 256; i++) mem[i] = 32'h80000000;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst.strobes", {ram_rd_o, cfg_wr_o, cfg_start_o, busy_o, done_o}, 0);
        chk("rst.ram_addr", ram_addr_o, 0);
        chk("rst.cfg_bus", {cfg_addr_o, cfg_data_o}, 0);
        chk("rst.err_cnt", {err_o, entry_cnt_o}, 0);

        // power-up auto-trigger: one run, none after the counter saturates
        cur_tbl = vecs[0].tbl;
        run_case("auto", 20, 1'b0, 1'b1);
        repeat (100) @(negedge clk);
        chk("auto.single_run_rd", rq.size(), 3);
        chk("auto.single_run_done", n_done, 1);

        // auto-trigger disabled
        rst_n = 1'b0; autostart_en_in = 1'b0;
        repeat (2) @(negedge clk);
        #1; clear_mon(); rst_n = 1'b1;
        repeat (3*PU) @(negedge clk);
        chk("noauto.rd", rq.size(), 0);
        chk("noauto.done", n_done, 0);

        for (int v = 0; v < 8; v++) begin
            cur_tbl = vecs[v].tbl;
            run_case($sformatf("vec%0d", v), vecs[v].dly, vecs[v].hold, 1'b0);
            chk($sformatf("vec%0d.tbl_cnt", v), d_cnt, vecs[v].exp_cnt);
            chk($sformatf("vec%0d.tbl_err", v), d_err, vecs[v].exp_err);
        end

        for (int r = 0; r < 12; r++) begin
            int m;
            for (int i = 0; i < 8; i++) cur_tbl[i] = $urandom & 32'h7FFFFFFF;
            m = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
            if (m < 8) cur_tbl[m] = $urandom | 32'h80000000;
            run_case($sformatf("rnd%0d", r), $urandom_range(0, 40), $urandom_range(0, 7) == 0, 1'b0);
        end

        // start pulse while waiting for the engine is dropped
        cur_tbl = vecs[0].tbl;
        for (int i = 0; i < 8; i++) mem[int'(BASE) + 4*i] = cur_tbl[i];
        resp_dly = 20;
        @(negedge clk); #1; clear_mon(); start_in = 1'b1;
        @(negedge clk); start_in = 1'b0;
        for (int k = 0; k < 100 && n_start == 0; k++) begin @(negedge clk); #1; end
        repeat (3) @(negedge clk);
        start_in = 1'b1;
        @(negedge clk); start_in = 1'b0;
        for (int k = 0; k < 100 && n_done == 0; k++) begin @(negedge clk); #1; end
        repeat (30) @(negedge clk);
        chk("midstart.n_start", n_start, 1);
        chk("midstart.n_done", n_done, 1);
        chk("midstart.n_rd", rq.size(), 3);

        // reset during the first WRITE aborts with all outputs low
        cur_tbl = '{32'h000500AB, 32'h00030155, 32'h80000000, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) mem[int'(BASE) + 4*i] = cur_tbl[i];
        @(negedge clk); #1; clear_mon(); start_in = 1'b1;
        @(negedge clk); start_in = 1'b0;
        for (int k = 0; k < 100 && wq.size() == 0; k++) begin @(negedge clk); #1; end
        chk("rstmid.in_write", cfg_wr_o, 1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rstmid.strobes", {ram_rd_o, cfg_wr_o, cfg_start_o, busy_o, done_o}, 0);
        chk("rstmid.ram_addr", ram_addr_o, 0);
        chk("rstmid.cfg_bus", {cfg_addr_o, cfg_data_o}, 0);
        chk("rstmid.err_cnt", {err_o, entry_cnt_o}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rstmid.n_wr", wq.size(), 1);
        chk("rstmid.n_start", n_start, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
